// File: rtl/stopwatch_lap.sv
// stopwatch_lap: HH:MM:SS stopwatch with prescaled tick, sticky alarm flag and a lap-capture buffer
module stopwatch_lap #(
  parameter int TICK_DIV = 1,
  parameter int HOUR_MAX = 24,
  parameter int LAP_DEPTH = 4,
  localparam int HW = $clog2(HOUR_MAX),
  localparam int LW = $clog2(LAP_DEPTH),
  localparam int CW = LW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          lap,
  input  logic          alarm_en,
  input  logic [5:0]    alarm_sec,
  input  logic [5:0]    alarm_min,
  input  logic [HW-1:0] alarm_hour,
  input  logic          ring_ack,
  input  logic          rd_en,
  input  logic [LW-1:0] rd_idx,
  output logic [5:0]    sec,
  output logic [5:0]    min,
  output logic [HW-1:0] hour,
  output logic          running,
  output logic          ring,
  output logic [CW-1:0] lap_count,
  output logic          lap_full,
  output logic          lap_ovf,
  output logic          rd_valid,
  output logic [5:0]    rd_sec,
  output logic [5:0]    rd_min,
  output logic [HW-1:0] rd_hour
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int TW = HW + 12;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;
  logic [1:0] rs, state, state_n;
  logic [PW-1:0] presc;
  logic act, tick, tick_q, wr, alarm_hit;
  logic [CW-1:0] count_n;
  logic [TW-1:0] cur, rd_data;
  logic [TW-1:0] mem [LAP_DEPTH];
  assign running = state == RUN;
  assign lap_full = lap_count == CW'(LAP_DEPTH);
  // The write pointer always equals the low bits of lap_count, since a full buffer stops writing.
  always_comb begin
    act = rs[1];
    state_n = clear ? IDLE : (stop && state == RUN) ? PAUSE : (start && state != RUN) ? RUN : state;
    tick = state == RUN && presc == PW'(TICK_DIV - 1);
    cur = {hour, min, sec};
    wr = lap && !clear && state != IDLE && !lap_full;
    count_n = clear ? '0 : lap_count + CW'(wr);
    rd_data = (wr && rd_idx == lap_count[LW-1:0]) ? cur : (CW'(rd_idx) < count_n) ? mem[rd_idx] : '0;
    alarm_hit = alarm_en && tick_q && cur == {alarm_hour, alarm_min, alarm_sec};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rs <= '0;
    else rs <= {rs[0], 1'b1};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      presc <= '0;
      {hour, min, sec} <= '0;
      tick_q <= 1'b0;
      ring <= 1'b0;
      lap_count <= '0;
      lap_ovf <= 1'b0;
      rd_valid <= 1'b0;
      {rd_hour, rd_min, rd_sec} <= '0;
    end else if (act) begin
      state <= state_n;
      lap_count <= count_n;
      tick_q <= tick && !clear;
      rd_valid <= rd_en;
      if (rd_en) {rd_hour, rd_min, rd_sec} <= rd_data;
      if (clear) begin
        presc <= '0;
        {hour, min, sec} <= '0;
        ring <= 1'b0;
        lap_ovf <= 1'b0;
      end else begin
        ring <= alarm_hit || (ring && !ring_ack);
        if (lap && state != IDLE && lap_full) lap_ovf <= 1'b1;
        if (tick) begin
          presc <= '0;
          sec <= sec == 6'd59 ? 6'd0 : sec + 6'd1;
          if (sec == 6'd59) begin
            min <= min == 6'd59 ? 6'd0 : min + 6'd1;
            if (min == 6'd59) hour <= hour == HW'(HOUR_MAX - 1) ? '0 : hour + HW'(1);
          end
        end else if (state == RUN) presc <= presc + PW'(1);
      end
    end
  end
  always_ff @(posedge clk)
    if (act && wr) mem[lap_count[LW-1:0]] <= cur;
endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: two stopwatch instances (fast/short-hour and prescaled) checked against a seconds-count model
module tb_stopwatch_lap;
  logic clk = 0, reset_n = 1;
  logic start = 0, stop = 0, clear = 0, lap = 0, alarm_en = 0, ring_ack = 0, rd_en = 0;
  logic [5:0] alarm_sec = 0, alarm_min = 0;
  logic [4:0] alarm_hour = 0;
  logic [1:0] rd_idx = 0;
  logic [5:0] a_sec, a_min, a_rs, a_rm, b_sec, b_min, b_rs, b_rm;
  logic [0:0] a_hour, a_rh;
  logic [4:0] b_hour, b_rh;
  logic a_running, a_ring, a_full, a_ovf, a_rv, b_running, b_ring, b_full, b_ovf, b_rv;
  logic [2:0] a_cnt, b_cnt;
  int n_chk = 0, n_fail = 0;
  int td[2] = '{1, 4};
  int hm[2] = '{2, 24};
  int st[2], presc[2], t[2], lc[2], ovf[2], ring[2], pend[2], ign[2], rv[2], rdt[2];
  int lt[2][4];

  stopwatch_lap #(.TICK_DIV(1), .HOUR_MAX(2), .LAP_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour[0:0]),
    .ring_ack(ring_ack), .rd_en(rd_en), .rd_idx(rd_idx), .sec(a_sec), .min(a_min), .hour(a_hour),
    .running(a_running), .ring(a_ring), .lap_count(a_cnt), .lap_full(a_full), .lap_ovf(a_ovf),
    .rd_valid(a_rv), .rd_sec(a_rs), .rd_min(a_rm), .rd_hour(a_rh));

  stopwatch_lap #(.TICK_DIV(4), .HOUR_MAX(24), .LAP_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .ring_ack(ring_ack), .rd_en(rd_en), .rd_idx(rd_idx), .sec(b_sec), .min(b_min), .hour(b_hour),
    .running(b_running), .ring(b_ring), .lap_count(b_cnt), .lap_full(b_full), .lap_ovf(b_ovf),
    .rd_valid(b_rv), .rd_sec(b_rs), .rd_min(b_rm), .rd_hour(b_rh));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [41:0] obs, logic [41:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Time is modelled as elapsed seconds; st: 0 idle, 1 run, 2 pause.
  function automatic logic [41:0] epack(int k);
    return {6'(t[k] % 60), 6'((t[k] / 60) % 60), 5'(t[k] / 3600), st[k] == 1, 1'(ring[k]),
            3'(lc[k]), lc[k] == 4, 1'(ovf[k]), 1'(rv[k]),
            6'(rdt[k] % 60), 6'((rdt[k] / 60) % 60), 5'(rdt[k] / 3600)};
  endfunction

  task automatic check_all();
    check("a_outputs", {a_sec, a_min, 5'(a_hour), a_running, a_ring, a_cnt, a_full, a_ovf, a_rv,
                        a_rs, a_rm, 5'(a_rh)}, epack(0));
    check("b_outputs", {b_sec, b_min, b_hour, b_running, b_ring, b_cnt, b_full, b_ovf, b_rv,
                        b_rs, b_rm, b_rh}, epack(1));
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      st[k] = 0; presc[k] = 0; t[k] = 0; lc[k] = 0; ovf[k] = 0; ring[k] = 0;
      pend[k] = 0; rv[k] = 0; rdt[k] = 0; ign[k] = 2;
    end
  endtask

  task automatic mstep();
    int tgt;
    tgt = int'(alarm_hour) * 3600 + int'(alarm_min) * 60 + int'(alarm_sec);
    for (int k = 0; k < 2; k++) begin
      int s0;
      if (!reset_n) continue;
      if (ign[k] > 0) begin
        ign[k]--;
        continue;
      end
      s0 = st[k];
      if (clear) begin
        st[k] = 0; presc[k] = 0; t[k] = 0; lc[k] = 0; ovf[k] = 0; ring[k] = 0; pend[k] = 0;
      end else begin
        ring[k] = (pend[k] != 0 && alarm_en) ? 1 : ring_ack ? 0 : ring[k];
        pend[k] = 0;
        if (lap && s0 != 0) begin
          if (lc[k] == 4) ovf[k] = 1;
          else begin
            lt[k][lc[k]] = t[k];
            lc[k]++;
          end
        end
        if (s0 == 1) begin
          if (presc[k] == td[k] - 1) begin
            presc[k] = 0;
            t[k] = (t[k] + 1) % (hm[k] * 3600);
            pend[k] = int'(t[k] == tgt);
          end else presc[k]++;
        end
        if (stop && s0 == 1) st[k] = 2;
        else if (start && s0 != 1) st[k] = 1;
      end
      rv[k] = int'(rd_en);
      if (rd_en) rdt[k] = int'(rd_idx) < lc[k] ? lt[k][rd_idx] : 0;
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      mstep();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic areset();
    #2 reset_n = 0;
    #1 mreset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #1 reset_n = 0;
    #1 mreset();
    check_all();
    repeat (2) @(negedge clk);
    reset_n = 1;
    cyc(4);
    // one hour boundary, then silent hour wrap on the HOUR_MAX=2 instance
    start = 1; cyc(1); start = 0;
    cyc(3599);
    check("a_005959", 42'({a_hour, a_min, a_sec}), 42'({1'b0, 6'd59, 6'd59}));
    cyc(1);
    check("a_010000", 42'({a_hour, a_min, a_sec}), 42'({1'b1, 6'd0, 6'd0}));
    cyc(3599);
    check("a_015959", 42'({a_hour, a_min, a_sec}), 42'({1'b1, 6'd59, 6'd59}));
    cyc(1);
    check("a_wrap_noring", 42'({a_hour, a_min, a_sec, a_ring}), 42'd0);
    clear = 1; cyc(1); clear = 0;
    // prescaler holds across a pause
    start = 1; cyc(1); start = 0;
    cyc(5);
    stop = 1; cyc(1); stop = 0;
    cyc(10);
    check("b_paused", 42'({b_running, b_sec}), 42'({1'b0, 6'd1}));
    start = 1; cyc(1); start = 0;
    check("b_resume0", 42'(b_sec), 42'd1);
    cyc(1);
    check("b_resume1", 42'(b_sec), 42'd1);
    cyc(1);
    check("b_resume2", 42'(b_sec), 42'd2);
    clear = 1; cyc(1); clear = 0;
    // laps and reads
    rd_en = 1; rd_idx = 2'd1; cyc(1); rd_en = 0;
    check("a_rd_empty", 42'({a_rv, a_rh, a_rm, a_rs}), 42'({1'b1, 13'd0}));
    start = 1; cyc(1); start = 0;
    cyc(1);
    lap = 1; cyc(5); lap = 0;
    check("a_lap_full", 42'({a_cnt, a_full, a_ovf}), 42'({3'd4, 1'b1, 1'b1}));
    rd_en = 1; rd_idx = 2'd3; cyc(1); rd_en = 0;
    check("a_rd_idx3", 42'({a_rv, a_rs}), 42'({1'b1, 6'd4}));
    cyc(1);
    check("a_rv_pulse", 42'(a_rv), 42'd0);
    clear = 1; cyc(1); clear = 0;
    start = 1; cyc(1); start = 0;
    cyc(2);
    lap = 1; rd_en = 1; rd_idx = 2'd0; cyc(1); lap = 0; rd_en = 0;
    check("a_rd_bypass", 42'({a_rv, a_rs}), 42'({1'b1, 6'd2}));
    clear = 1; cyc(1); clear = 0;
    // alarm at 00:00:05, ack, and set-beats-ack on the slow instance
    alarm_sec = 6'd5; alarm_en = 1;
    start = 1; cyc(1); start = 0;
    cyc(5);
    check("a_sec5_noring", 42'({a_sec, a_ring}), 42'({6'd5, 1'b0}));
    cyc(1);
    check("a_ring_set", 42'(a_ring), 42'd1);
    ring_ack = 1; cyc(1);
    check("a_ring_ack", 42'(a_ring), 42'd0);
    cyc(14);
    check("b_ring_set_wins", 42'({b_sec, b_ring}), 42'({6'd5, 1'b1}));
    cyc(1);
    check("b_ring_ack", 42'(b_ring), 42'd0);
    ring_ack = 0;
    clear = 1; start = 1; lap = 1; cyc(1); clear = 0; start = 0; lap = 0;
    check("a_clear_wins", 42'({a_running, a_cnt, a_sec}), 42'd0);
    // randomized traffic with one asynchronous reset in the middle
    alarm_sec = 6'd3;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      clear = r < 2;
      stop = r >= 2 && r < 7;
      start = r >= 7 && r < 14;
      lap = $urandom_range(0, 7) == 0;
      rd_en = $urandom_range(0, 3) == 0;
      rd_idx = 2'($urandom_range(0, 3));
      ring_ack = $urandom_range(0, 15) == 0;
      alarm_en = $urandom_range(0, 3) != 0;
      if (i == 1500) areset();
      cyc(1);
    end
    {clear, stop, start, lap, rd_en, ring_ack, alarm_en} = '0;
    clear = 1; cyc(1); clear = 0;
    // reset mid-run and mid-read, then synchronised release
    start = 1; cyc(1); start = 0;
    cyc(7);
    check("a_sec7", 42'(a_sec), 42'd7);
    rd_en = 1;
    #2 reset_n = 0;
    #1 check("a_async_reset", 42'({a_sec, a_running, a_rv, a_cnt}), 42'd0);
    mreset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rd_en = 0;
    reset_n = 1;
    start = 1;
    cyc(2);
    check("a_release_hold", 42'(a_running), 42'd0);
    cyc(1); start = 0;
    check("a_release_run", 42'(a_running), 42'd1);
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
